// File: rtl/commit_trace_checker.sv
// commit_trace_checker: compares the processor's commit stream against a
// queue of expected trace entries, counting commits and mismatches and
// recording the first divergence. Reports pass/fail once halt commits.
module commit_trace_checker #(
    parameter int DEPTH            = 8,
    parameter int STOP_ON_MISMATCH = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [15:0]              commit_pc,
    input  logic                     reg_write,
    input  logic [2:0]               write_reg,
    input  logic [15:0]              write_data,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [15:0]              mem_addr,
    input  logic [15:0]              mem_data,
    input  logic                     halt,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [2:0]               exp_kind,
    input  logic [15:0]              exp_pc,
    input  logic [15:0]              exp_val,
    input  logic [15:0]              exp_addr,
    input  logic [15:0]              exp_mdata,
    input  logic [2:0]               exp_reg,
    output logic [15:0]              inst_cnt,
    output logic [15:0]              mismatch_cnt,
    output logic [15:0]              first_bad_inum,
    output logic [15:0]              first_bad_pc,
    output logic                     underflow,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               dbgState,
    output logic [$clog2(DEPTH):0]   dbgCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] KIND_NOP  = 3'd0;
    localparam logic [2:0] KIND_REG  = 3'd1;
    localparam logic [2:0] KIND_LD   = 3'd2;
    localparam logic [2:0] KIND_ST   = 3'd3;
    localparam logic [2:0] KIND_STU  = 3'd4;
    localparam logic [2:0] KIND_HALT = 3'd5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DONE    = 2'd1,
        STOPPED = 2'd2
    } stateT;

    // 70-bit expected entry.
    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] pc;
        logic [2:0]  regNum;
        logic [15:0] val;
        logic [15:0] addr;
        logic [15:0] mdata;
    } entryT;

    stateT          state;
    stateT          stateNext;
    entryT          fifoMem [DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;
    logic [CW-1:0]  count;
    entryT          head;
    entryT          pushEntry;
    logic [2:0]     commitKind;
    logic           fieldBad;
    logic           isMismatch;
    logic           running;
    logic           fifoEmpty;
    logic           fifoFull;
    logic           doPush;
    logic           doCommit;
    logic           doPop;
    logic           badCommit;

    // Expected-entry port: an entry transfers on a rising edge where
    // exp_valid and exp_ready are both high. exp_ready depends only on
    // registered state and occupancy, never on a pop in the same cycle,
    // and the loader may hold exp_valid and the entry fields until accepted.
    assign running   = (state == RUN);
    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == CW'(DEPTH));
    assign exp_ready = running & ~fifoFull;
    assign doPush    = exp_valid & exp_ready;
    assign doCommit  = running & commit_valid;
    assign doPop     = doCommit & ~fifoEmpty;
    assign badCommit = doPop & isMismatch;

    assign head      = fifoMem[rdPtr];
    assign pushEntry = '{kind: exp_kind, pc: exp_pc, regNum: exp_reg,
                         val: exp_val, addr: exp_addr, mdata: exp_mdata};

    assign done     = (state != RUN);
    assign pass     = done & (mismatch_cnt == 16'd0) & ~underflow;
    assign dbgState = state;
    assign dbgCount = count;

    // Classify the committing instruction; the first matching rule wins.
    always_comb begin
        commitKind = KIND_NOP;
        if (reg_write && mem_write)     commitKind = KIND_STU;
        else if (reg_write && mem_read) commitKind = KIND_LD;
        else if (reg_write)             commitKind = KIND_REG;
        else if (halt)                  commitKind = KIND_HALT;
        else if (mem_write)             commitKind = KIND_ST;
    end

    // Compare only the fields the expected kind cares about; illegal kinds always mismatch.
    always_comb begin
        fieldBad = 1'b0;
        case (head.kind)
            KIND_NOP, KIND_HALT: fieldBad = (head.pc != commit_pc);
            KIND_REG: fieldBad = (head.pc != commit_pc) | (head.regNum != write_reg) |
                                 (head.val != write_data);
            KIND_LD:  fieldBad = (head.pc != commit_pc) | (head.regNum != write_reg) |
                                 (head.val != write_data) | (head.addr != mem_addr);
            KIND_ST:  fieldBad = (head.pc != commit_pc) | (head.addr != mem_addr) |
                                 (head.mdata != mem_data);
            KIND_STU: fieldBad = (head.pc != commit_pc) | (head.regNum != write_reg) |
                                 (head.val != write_data) | (head.addr != mem_addr) |
                                 (head.mdata != mem_data);
            default:  fieldBad = 1'b1;
        endcase
        isMismatch = fieldBad | (head.kind != commitKind);
    end

    // Next state: a halt commit wins over stop-on-mismatch; DONE and STOPPED hold until reset.
    always_comb begin
        stateNext = state;
        case (state)
            RUN: begin
                if (doCommit && (commitKind == KIND_HALT))
                    stateNext = DONE;
                else if (badCommit && (STOP_ON_MISMATCH != 0))
                    stateNext = STOPPED;
            end
            default: stateNext = state;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= stateNext;
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (doPush) fifoMem[wrPtr] <= pushEntry;
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Commit bookkeeping: instruction count, sticky underflow, mismatch tally and first divergence.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_cnt       <= '0;
            mismatch_cnt   <= '0;
            first_bad_inum <= '0;
            first_bad_pc   <= '0;
            underflow      <= 1'b0;
        end else begin
            if (doCommit) begin
                inst_cnt <= inst_cnt + 16'd1;
                if (fifoEmpty) underflow <= 1'b1;
            end
            if (badCommit) begin
                if (mismatch_cnt == 16'd0) begin
                    first_bad_inum <= inst_cnt;
                    first_bad_pc   <= commit_pc;
                end
                if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Bench for commit_trace_checker: directed test-plan scenarios followed by a
// randomized push/commit stream, all checked against a queue-based model.
module tb_commit_trace_checker;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] pc;
        logic [2:0]  rg;
        logic [15:0] val;
        logic [15:0] addr;
        logic [15:0] mdata;
    } entry_t;

    typedef struct packed {
        logic [15:0] pc;
        logic        rw;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic        mr;
        logic        mw;
        logic [15:0] maddr;
        logic [15:0] mdata;
        logic        hlt;
    } commit_t;

    logic clk, rst;
    logic commit_valid, reg_write, mem_read, mem_write, halt, exp_valid;
    logic [15:0] commit_pc, write_data, mem_addr, mem_data;
    logic [2:0] write_reg, exp_kind, exp_reg;
    logic [15:0] exp_pc, exp_val, exp_addr, exp_mdata;

    logic exp_ready, underflow, done, pass;
    logic [15:0] inst_cnt, mismatch_cnt, first_bad_inum, first_bad_pc;
    logic [1:0] dbgState;
    logic [CW-1:0] dbgCount;

    logic stopExpReady, stopUnderflow, stopDone, stopPass;
    logic [15:0] stopInst, stopMis, stopFirstInum, stopFirstPc;
    logic [1:0] stopDbgState;
    logic [CW-1:0] stopDbgCount;

    commit_trace_checker #(.DEPTH(DEPTH), .STOP_ON_MISMATCH(0)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .halt(halt), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_kind(exp_kind), .exp_pc(exp_pc), .exp_val(exp_val), .exp_addr(exp_addr),
        .exp_mdata(exp_mdata), .exp_reg(exp_reg), .inst_cnt(inst_cnt),
        .mismatch_cnt(mismatch_cnt), .first_bad_inum(first_bad_inum),
        .first_bad_pc(first_bad_pc), .underflow(underflow), .done(done), .pass(pass),
        .dbgState(dbgState), .dbgCount(dbgCount)
    );

    commit_trace_checker #(.DEPTH(DEPTH), .STOP_ON_MISMATCH(1)) dutStop (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .halt(halt), .exp_valid(exp_valid), .exp_ready(stopExpReady),
        .exp_kind(exp_kind), .exp_pc(exp_pc), .exp_val(exp_val), .exp_addr(exp_addr),
        .exp_mdata(exp_mdata), .exp_reg(exp_reg), .inst_cnt(stopInst),
        .mismatch_cnt(stopMis), .first_bad_inum(stopFirstInum),
        .first_bad_pc(stopFirstPc), .underflow(stopUnderflow), .done(stopDone),
        .pass(stopPass), .dbgState(stopDbgState), .dbgCount(stopDbgCount)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    entry_t      exp_q[$];
    commit_t     fut_q[$];
    logic [15:0] mInst, mMis, mFirstInum, mFirstPc;
    logic        mUnder;
    int          mState;            // 0 running, 1 finished
    int          testsRun = 0;
    int          failCount = 0;

    function automatic logic [2:0] classify(input commit_t c);
        if (c.rw && c.mw) return 3'd4;
        if (c.rw && c.mr) return 3'd2;
        if (c.rw)         return 3'd1;
        if (c.hlt)        return 3'd5;
        if (c.mw)         return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic differs(input entry_t e, input commit_t c);
        logic usesReg, usesAddr, usesMdata;
        if (e.kind > 3'd5) return 1'b1;
        if (e.kind != classify(c)) return 1'b1;
        usesReg   = (e.kind == 3'd1) || (e.kind == 3'd2) || (e.kind == 3'd4);
        usesAddr  = (e.kind == 3'd2) || (e.kind == 3'd3) || (e.kind == 3'd4);
        usesMdata = (e.kind == 3'd3) || (e.kind == 3'd4);
        return (e.pc != c.pc) ||
               (usesReg && ((e.rg != c.wreg) || (e.val != c.wdata))) ||
               (usesAddr && (e.addr != c.maddr)) ||
               (usesMdata && (e.mdata != c.mdata));
    endfunction

    function automatic entry_t expectFor(input commit_t c);
        entry_t e;
        e.kind = classify(c); e.pc = c.pc; e.rg = c.wreg; e.val = c.wdata;
        e.addr = c.maddr; e.mdata = c.mdata;
        return e;
    endfunction

    function automatic commit_t mkC(input logic [15:0] pc, input logic rw, input logic [2:0] wreg,
                                    input logic [15:0] wdata, input logic mr, input logic mw,
                                    input logic [15:0] maddr, input logic [15:0] mdata,
                                    input logic hlt);
        commit_t c;
        c.pc = pc; c.rw = rw; c.wreg = wreg; c.wdata = wdata; c.mr = mr; c.mw = mw;
        c.maddr = maddr; c.mdata = mdata; c.hlt = hlt;
        return c;
    endfunction

    function automatic entry_t mkE(input logic [2:0] kind, input logic [15:0] pc,
                                   input logic [2:0] rg, input logic [15:0] val,
                                   input logic [15:0] addr, input logic [15:0] mdata);
        entry_t e;
        e.kind = kind; e.pc = pc; e.rg = rg; e.val = val; e.addr = addr; e.mdata = mdata;
        return e;
    endfunction

    function automatic commit_t randCommit();
        return mkC(16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        testsRun++;
        assert (obs === expv) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkAll();
        check("inst_cnt", inst_cnt, mInst);
        check("mismatch_cnt", mismatch_cnt, mMis);
        check("first_bad_inum", first_bad_inum, mFirstInum);
        check("first_bad_pc", first_bad_pc, mFirstPc);
        check("underflow", 16'(underflow), 16'(mUnder));
        check("done", 16'(done), 16'(mState != 0));
        check("pass", 16'(pass), 16'((mState != 0) && (mMis == 16'd0) && !mUnder));
        check("count", 16'(dbgCount), 16'(exp_q.size()));
        check("exp_ready", 16'(exp_ready), 16'((mState == 0) && (exp_q.size() != DEPTH)));
    endtask

    // Driver tasks
    task automatic driveIdle();
        commit_valid = 0; commit_pc = 0; reg_write = 0; write_reg = 0; write_data = 0;
        mem_read = 0; mem_write = 0; mem_addr = 0; mem_data = 0; halt = 0;
        exp_valid = 0; exp_kind = 0; exp_pc = 0; exp_val = 0; exp_addr = 0;
        exp_mdata = 0; exp_reg = 0;
    endtask

    task automatic modelClear();
        exp_q.delete(); fut_q.delete();
        mInst = 0; mMis = 0; mFirstInum = 0; mFirstPc = 0; mUnder = 0; mState = 0;
    endtask

    task automatic doReset();
        driveIdle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        modelClear();
        checkAll();
    endtask

    // One clock: drive a commit and/or an offered entry, advance the model, check everything.
    task automatic cycle(input logic doC, input commit_t c, input logic doP, input entry_t e,
                         output logic acc);
        logic   modelReady;
        entry_t h;
        commit_valid = doC; commit_pc = c.pc; reg_write = c.rw; write_reg = c.wreg;
        write_data = c.wdata; mem_read = c.mr; mem_write = c.mw; mem_addr = c.maddr;
        mem_data = c.mdata; halt = c.hlt;
        exp_valid = doP; exp_kind = e.kind; exp_pc = e.pc; exp_reg = e.rg;
        exp_val = e.val; exp_addr = e.addr; exp_mdata = e.mdata;
        modelReady = (mState == 0) && (exp_q.size() < DEPTH);
        acc = doP && modelReady;
        check("exp_ready_pre", 16'(exp_ready), 16'(modelReady));
        @(posedge clk); #1;
        if (doC && mState == 0) begin
            if (exp_q.size() == 0) mUnder = 1'b1;
            else begin
                h = exp_q.pop_front();
                if (differs(h, c)) begin
                    if (mMis == 16'd0) begin
                        mFirstInum = mInst;
                        mFirstPc   = c.pc;
                    end
                    if (mMis != 16'hFFFF) mMis = mMis + 16'd1;
                end
            end
            if (classify(c) == 3'd5) mState = 1;
            mInst = mInst + 16'd1;
        end
        if (acc) exp_q.push_back(e);
        driveIdle();
        checkAll();
    endtask

    initial begin
        commit_t nullC, c, nc;
        entry_t  nullE, e;
        logic    acc;
        nullC = '0;
        nullE = '0;

        // Power-on reset
        driveIdle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        modelClear();
        checkAll();

        // Matched stream
        doReset();
        cycle(0, nullC, 1, mkE(3'd1, 16'h0000, 3'd1, 16'h0005, 16'h0, 16'h0), acc);
        cycle(0, nullC, 1, mkE(3'd3, 16'h0002, 3'd0, 16'h0, 16'h0010, 16'h0005), acc);
        cycle(0, nullC, 1, mkE(3'd5, 16'h0004, 3'd0, 16'h0, 16'h0, 16'h0), acc);
        cycle(1, mkC(16'h0000, 1, 3'd1, 16'h0005, 0, 0, 16'h0, 16'h0, 0), 0, nullE, acc);
        cycle(1, mkC(16'h0002, 0, 3'd0, 16'h0, 0, 1, 16'h0010, 16'h0005, 0), 0, nullE, acc);
        cycle(1, mkC(16'h0004, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1), 0, nullE, acc);
        check("match_inst", inst_cnt, 16'd3);
        check("match_mis", mismatch_cnt, 16'd0);
        check("match_done", 16'(done), 16'd1);
        check("match_pass", 16'(pass), 16'd1);

        // Single mismatch on load data
        doReset();
        cycle(0, nullC, 1, mkE(3'd2, 16'h0006, 3'd2, 16'h1234, 16'h0020, 16'h0), acc);
        cycle(0, nullC, 1, mkE(3'd5, 16'h0008, 3'd0, 16'h0, 16'h0, 16'h0), acc);
        cycle(1, mkC(16'h0006, 1, 3'd2, 16'h1235, 1, 0, 16'h0020, 16'h0, 0), 0, nullE, acc);
        cycle(1, mkC(16'h0008, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1), 0, nullE, acc);
        check("mis_cnt", mismatch_cnt, 16'd1);
        check("mis_inum", first_bad_inum, 16'd0);
        check("mis_pc", first_bad_pc, 16'h0006);
        check("mis_pass", 16'(pass), 16'd0);
        check("mis_done", 16'(done), 16'd1);

        // Kind mismatch freezes the stop-on-mismatch instance
        doReset();
        cycle(0, nullC, 1, mkE(3'd0, 16'h0100, 3'd0, 16'h0, 16'h0, 16'h0), acc);
        cycle(0, nullC, 1, mkE(3'd0, 16'h0102, 3'd0, 16'h0, 16'h0, 16'h0), acc);
        cycle(1, mkC(16'h0100, 1, 3'd3, 16'h0007, 0, 1, 16'h0040, 16'h0009, 0), 0, nullE, acc);
        check("stop_done", 16'(stopDone), 16'd1);
        check("stop_ready", 16'(stopExpReady), 16'd0);
        check("stop_inst", stopInst, 16'd1);
        check("stop_mis", stopMis, 16'd1);
        check("stop_pass", 16'(stopPass), 16'd0);
        cycle(1, mkC(16'h0102, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0), 0, nullE, acc);
        cycle(1, mkC(16'h0104, 1, 3'd1, 16'h0001, 0, 0, 16'h0, 16'h0, 0), 0, nullE, acc);
        check("stop_inst_hold", stopInst, 16'd1);
        check("stop_done_hold", 16'(stopDone), 16'd1);
        check("nostop_running", 16'(done), 16'd0);

        // Underflow with a same-cycle push (no bypass)
        doReset();
        cycle(1, mkC(16'h0030, 1, 3'd4, 16'h00AA, 0, 0, 16'h0, 16'h0, 0),
              1, mkE(3'd1, 16'h0030, 3'd4, 16'h00AA, 16'h0, 16'h0), acc);
        check("uf_flag", 16'(underflow), 16'd1);
        check("uf_count", 16'(dbgCount), 16'd1);
        check("uf_inst", inst_cnt, 16'd1);
        check("uf_mis", mismatch_cnt, 16'd0);

        // Fill to DEPTH, then push and pop together for 3*DEPTH cycles
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            c = randCommit();
            cycle(0, nullC, 1, expectFor(c), acc);
            if (acc) fut_q.push_back(c);
        end
        check("full_ready", 16'(exp_ready), 16'd0);
        check("full_count", 16'(dbgCount), 16'(DEPTH));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            nc = randCommit();
            c  = fut_q.pop_front();
            if (exp_q.size() == DEPTH) check("wrap_full_ready", 16'(exp_ready), 16'd0);
            cycle(1, c, 1, expectFor(nc), acc);
            if (acc) fut_q.push_back(nc);
        end
        check("wrap_mis", mismatch_cnt, 16'd0);
        check("wrap_inst", inst_cnt, 16'(3 * DEPTH));

        // Reset mid-operation with 5 entries queued and two mismatches
        doReset();
        for (int i = 0; i < 7; i++) begin
            c = randCommit();
            cycle(0, nullC, 1, expectFor(c), acc);
            if (acc) fut_q.push_back(c);
        end
        for (int i = 0; i < 2; i++) begin
            c = fut_q.pop_front();
            c.pc = c.pc ^ 16'h0001;
            cycle(1, c, 0, nullE, acc);
        end
        check("pre_rst_mis", mismatch_cnt, 16'd2);
        check("pre_rst_count", 16'(dbgCount), 16'd5);
        doReset();
        check("rst_inst", inst_cnt, 16'd0);
        check("rst_mis", mismatch_cnt, 16'd0);
        check("rst_inum", first_bad_inum, 16'd0);
        check("rst_pc", first_bad_pc, 16'd0);
        check("rst_uf", 16'(underflow), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_pass", 16'(pass), 16'd0);
        check("rst_count", 16'(dbgCount), 16'd0);
        check("rst_ready", 16'(exp_ready), 16'd1);

        // Randomized stream with occasional corrupted expectations
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic doC, doP;
            nc = randCommit();
            e  = expectFor(nc);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 5))
                    0: e.kind  = 3'($urandom_range(0, 7));
                    1: e.val   = e.val ^ (16'd1 << $urandom_range(0, 15));
                    2: e.addr  = e.addr ^ (16'd1 << $urandom_range(0, 15));
                    3: e.mdata = e.mdata ^ (16'd1 << $urandom_range(0, 15));
                    4: e.rg    = e.rg ^ 3'd1;
                    default: e.pc = e.pc ^ 16'h8000;
                endcase
            end
            doP = ($urandom_range(0, 2) != 0);
            doC = ($urandom_range(0, 3) != 0) && ((exp_q.size() > 0) || (i > 350));
            if (doC && exp_q.size() > 0) c = fut_q.pop_front();
            else                         c = randCommit();
            cycle(doC, c, doP, e, acc);
            if (acc) fut_q.push_back(nc);
        end
        cycle(1, mkC(16'hFFFE, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1), 0, nullE, acc);
        check("rand_done", 16'(done), 16'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
